formal_stream_scoreboard: RTL and testbench
===========================================

// Module: formal_stream_scoreboard
// PURPOSE
// - Reader/checker end of the formal selftest streams. Consumes the actual output stream of the
//   cipher datapath and pops expected words from the formal_fifo read side (m_valid/m_ready/m_data).
// - Compares word by word, applies pseudo-random backpressure and checks handshake protocol.
// - Raises sticky error flags for mismatch, protocol violation or stall timeout.
// PARAMETERS
// - dw        32       data word width (same as the FIFO dw)
// - cw        16       width of pass_count
// - tw        10       timeout counter width; timeout after 2**tw-1 starved cycles
// - stall_en  1        1: LFSR-driven backpressure on s_ready; 0: never stall
// - seed      16'hACE1 LFSR seed; value 0 is replaced by 16'h0001
// PORTS
// - clk           in   1   clock, all logic on posedge
// - resetn        in   1   asynchronous, active-low reset
// - s_valid       in   1   actual stream valid (from DUT)
// - s_ready       out  1   actual stream ready
// - s_data        in   dw  actual stream data
// - e_valid       in   1   expected stream valid (formal_fifo m_valid)
// - e_ready       out  1   expected stream pop (to formal_fifo m_ready)
// - e_data        in   dw  expected word (formal_fifo m_data, asynchronous read)
// - pass_count    out  cw  number of matching words, saturating
// - err_mismatch  out  1   sticky: accepted word != expected word
// - err_protocol  out  1   sticky: s_valid dropped or s_data changed while stalled
// - err_timeout   out  1   sticky: expected word pending, DUT silent too long
// BEHAVIOUR
// - Reset (resetn=0, asynchronous): state=RUN; lfsr=seed; pass_count=0; all err_*=0;
//   timeout counter=0; protocol history cleared. s_ready and e_ready are combinational and are 0 in FAIL.
// - States: RUN, FAIL. RUN->FAIL on any error detected this cycle. FAIL exits only on reset.
// - stall = stall_en && (lfsr[1:0]==2'b00), about 25%. LFSR is 16-bit Fibonacci
//   x^16+x^14+x^13+x^11+1 and advances every cycle in both states.
// - s_ready = (state==RUN) && e_valid && !stall. An expected word must exist before a word is accepted.
// - e_ready = s_valid && s_ready. Zero latency: the FIFO pops in the same cycle as the accept.
// - Compare on accept (acc = s_valid && s_ready):
//   - s_data==e_data: pass_count+1, saturating at all-ones.
//   - otherwise: err_mismatch<=1, FAIL.
// - Protocol check:
//   - Register pend = s_valid && !s_ready and pdat = s_data.
//   - Next cycle, pend && (!s_valid || s_data!=pdat) -> err_protocol<=1, FAIL.
//   - Reset clears pend.
// - Timeout:
//   - Counter increments when state==RUN && e_valid && !s_valid.
//   - It clears on acc or when !e_valid.
//   - At 2**tw-1: err_timeout<=1, FAIL. Stalls caused by this block never count.
// - Simultaneous errors in one cycle: every applicable flag is set. pass_count is not incremented on a mismatch.
// - e_valid=0 (FIFO empty) with s_valid=1: s_ready=0 and the DUT stalls legally. No error and no timeout.
// - A reset in mid-transfer drops any word in flight. Both stream sides must restart from reset.
// STRUCTURE
// - Shared package formal_pkg:
//   - state encodings ST_RUN=1'b0, ST_FAIL=1'b1
//   - LFSR_TAPS=16'hB400 and the default seed
// - Sub-module formal_lfsr (width, taps, seed; ports clk, resetn, q): shared with the source-side stimulus block.
// - The rest is flat: state register, compare, timeout counter, protocol history.
// TESTING (bench: formal_fifo filled with expected words, DUT modelled by a second formal_fifo)
// - stall_en=0, 4 identical words 1,2,3,4 on both sides -> 4 accepts in 4 cycles, pass_count=4, no errors.
// - stall_en=1, 64 identical words -> pass_count=64, e_ready==acc every cycle, no errors.
// - 3rd actual word 32'hDEAD vs expected 32'hBEEF -> err_mismatch=1 the next cycle.
//   pass_count stays 2, and s_ready=0 afterwards.
// - Force stall, s_valid=1 then s_data changes while s_ready=0 -> err_protocol=1 the next cycle.
// - tw=4, expected FIFO non-empty, s_valid held 0 -> err_timeout=1 after 15 cycles. At 14 cycles, no error.
// - resetn pulsed low mid-stream (asynchronous, off-edge) -> all outputs 0 immediately, then normal checking.

Source files
------------

// File: rtl/formal_pkg.sv
// Shared definitions for the formal selftest stream blocks: FSM encodings and
// the LFSR polynomial/seed used by both the source and the checker side.
package formal_pkg;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_FAIL = 1'b1;

    // x^16 + x^14 + x^13 + x^11 + 1, tap bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/formal_lfsr.sv
// Left-shifting Fibonacci LFSR, advancing every clock. An all-zero seed would
// lock the register, so it is replaced by 1.
module formal_lfsr #(
    parameter int               width = 16,
    parameter logic [width-1:0] taps  = 16'hB400,
    parameter logic [width-1:0] seed  = 16'hACE1
) (
    input  logic             clk,
    input  logic             resetn,
    output logic [width-1:0] q
);

    localparam logic [width-1:0] SEED_EFF =
        (seed == '0) ? {{(width-1){1'b0}}, 1'b1} : seed;

    logic [width-1:0] q_q;
    logic [width-1:0] q_d;

    always_comb begin
        q_d = {q_q[width-2:0], ^(q_q & taps)};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_q <= SEED_EFF;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/formal_stream_scoreboard.sv
// Checker end of the formal selftest: accepts the actual stream only while an
// expected word is available, compares word by word and latches sticky errors.
module formal_stream_scoreboard
    import formal_pkg::*;
#(
    parameter int          dw       = 32,
    parameter int          cw       = 16,
    parameter int          tw       = 10,
    parameter bit          stall_en = 1'b1,
    parameter logic [15:0] seed     = DEFAULT_SEED
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [dw-1:0] s_data,
    input  logic          e_valid,
    output logic          e_ready,
    input  logic [dw-1:0] e_data,
    output logic [cw-1:0] pass_count,
    output logic          err_mismatch,
    output logic          err_protocol,
    output logic          err_timeout,
    output logic          dbg_state
);

    // Handshake: a word moves when valid && ready on a rising edge. Once the
    // sender raises valid it must hold valid and data until ready is seen.
    // e_ready is the same-cycle pop of the expected FIFO for each accept.

    localparam logic [tw-1:0] TMO_LAST = tw'(2**tw - 2);

    logic [15:0]   lfsr;
    logic          run;
    logic          stall;
    logic          acc;
    logic          mis_hit;
    logic          pro_hit;
    logic          tmo_inc;
    logic          tmo_hit;

    logic [0:0]    state_q,   state_d;
    logic [cw-1:0] pass_q,    pass_d;
    logic          mis_q,     mis_d;
    logic          pro_q,     pro_d;
    logic          tmo_err_q, tmo_err_d;
    logic [tw-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          pend_q,    pend_d;
    logic [dw-1:0] pdat_q,    pdat_d;

    formal_lfsr #(
        .width (16),
        .taps  (LFSR_TAPS),
        .seed  (seed)
    ) u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .q      (lfsr)
    );

    assign run     = (state_q == ST_RUN);
    assign stall   = stall_en && (lfsr[1:0] == 2'b00);
    assign s_ready = run && e_valid && !stall;
    assign e_ready = s_valid && s_ready;
    assign acc     = e_ready;

    always_comb begin
        mis_hit = acc && (s_data != e_data);
        pro_hit = pend_q && (!s_valid || (s_data != pdat_q));
        // Starvation only counts while an expected word waits and the DUT is silent.
        tmo_inc = run && e_valid && !s_valid;
        tmo_hit = tmo_inc && (tmo_cnt_q == TMO_LAST);

        state_d   = (mis_hit || pro_hit || tmo_hit) ? ST_FAIL : state_q;
        mis_d     = mis_q || mis_hit;
        pro_d     = pro_q || pro_hit;
        tmo_err_d = tmo_err_q || tmo_hit;

        pass_d = pass_q;
        if (acc && !mis_hit && (pass_q != {cw{1'b1}})) begin
            pass_d = pass_q + cw'(1);
        end

        tmo_cnt_d = tmo_cnt_q;
        if (acc || !e_valid) begin
            tmo_cnt_d = '0;
        end else if (tmo_inc) begin
            tmo_cnt_d = tmo_cnt_q + tw'(1);
        end

        pend_d = s_valid && !s_ready;
        pdat_d = s_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_RUN;
            pass_q    <= '0;
            mis_q     <= 1'b0;
            pro_q     <= 1'b0;
            tmo_err_q <= 1'b0;
            tmo_cnt_q <= '0;
            pend_q    <= 1'b0;
            pdat_q    <= '0;
        end else begin
            state_q   <= state_d;
            pass_q    <= pass_d;
            mis_q     <= mis_d;
            pro_q     <= pro_d;
            tmo_err_q <= tmo_err_d;
            tmo_cnt_q <= tmo_cnt_d;
            pend_q    <= pend_d;
            pdat_q    <= pdat_d;
        end
    end

    assign pass_count   = pass_q;
    assign err_mismatch = mis_q;
    assign err_protocol = pro_q;
    assign err_timeout  = tmo_err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_formal_stream_scoreboard.sv
// Bench for formal_stream_scoreboard: a no-stall, narrow instance for directed
// vectors and corner cases, and a stalling instance for a randomized stream.
module tb_formal_stream_scoreboard;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // instance A: stall_en=0, cw=3 (saturation reachable), tw=4
    logic        a_s_valid, a_s_ready, a_e_valid, a_e_ready;
    logic [31:0] a_s_data, a_e_data;
    logic [2:0]  a_pass;
    logic        a_mis, a_pro, a_tmo, a_state;

    // instance B: stall_en=1, default widths
    logic        b_s_valid, b_s_ready, b_e_valid, b_e_ready;
    logic [31:0] b_s_data, b_e_data;
    logic [15:0] b_pass;
    logic        b_mis, b_pro, b_tmo, b_state;

    formal_stream_scoreboard #(
        .dw(32), .cw(3), .tw(4), .stall_en(1'b0), .seed(16'hACE1)
    ) dut_a (
        .clk(clk), .resetn(resetn),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .e_valid(a_e_valid), .e_ready(a_e_ready), .e_data(a_e_data),
        .pass_count(a_pass), .err_mismatch(a_mis), .err_protocol(a_pro),
        .err_timeout(a_tmo), .dbg_state(a_state)
    );

    formal_stream_scoreboard #(
        .dw(32), .cw(16), .tw(10), .stall_en(1'b1), .seed(16'hACE1)
    ) dut_b (
        .clk(clk), .resetn(resetn),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .e_valid(b_e_valid), .e_ready(b_e_ready), .e_data(b_e_data),
        .pass_count(b_pass), .err_mismatch(b_mis), .err_protocol(b_pro),
        .err_timeout(b_tmo), .dbg_state(b_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        a_s_valid = 1'b0; a_s_data = '0; a_e_valid = 1'b0; a_e_data = '0;
        b_s_valid = 1'b0; b_s_data = '0; b_e_valid = 1'b0; b_e_data = '0;
    endtask

    // Leaves the bench at a falling edge with reset released.
    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic check_a_flags(input string tag, input logic [2:0] pc,
                                 input logic mis, input logic pro, input logic tmo,
                                 input logic st);
        check({tag, " pass_count"},   32'(a_pass),  32'(pc));
        check({tag, " err_mismatch"}, 32'(a_mis),   32'(mis));
        check({tag, " err_protocol"}, 32'(a_pro),   32'(pro));
        check({tag, " err_timeout"},  32'(a_tmo),   32'(tmo));
        check({tag, " state"},        32'(a_state), 32'(st));
    endtask

    typedef struct {
        logic        sv;
        logic [31:0] sd;
        logic        ev;
        logic [31:0] ed;
        logic        exp_sr;
        logic        exp_er;
        logic [2:0]  exp_pc;
    } vec_t;

    vec_t vecs[12];

    task automatic run_vectors();
        vecs[0]  = '{1'b1, 32'd1,  1'b1, 32'd1,  1'b1, 1'b1, 3'd1};
        vecs[1]  = '{1'b1, 32'd2,  1'b1, 32'd2,  1'b1, 1'b1, 3'd2};
        vecs[2]  = '{1'b1, 32'd3,  1'b1, 32'd3,  1'b1, 1'b1, 3'd3};
        vecs[3]  = '{1'b1, 32'd4,  1'b1, 32'd4,  1'b1, 1'b1, 3'd4};
        vecs[4]  = '{1'b1, 32'd5,  1'b0, 32'd0,  1'b0, 1'b0, 3'd4};
        vecs[5]  = '{1'b1, 32'd5,  1'b1, 32'd5,  1'b1, 1'b1, 3'd5};
        vecs[6]  = '{1'b0, 32'd0,  1'b0, 32'd0,  1'b0, 1'b0, 3'd5};
        vecs[7]  = '{1'b0, 32'd0,  1'b1, 32'd16, 1'b1, 1'b0, 3'd5};
        vecs[8]  = '{1'b1, 32'd16, 1'b1, 32'd16, 1'b1, 1'b1, 3'd6};
        vecs[9]  = '{1'b1, 32'd7,  1'b1, 32'd7,  1'b1, 1'b1, 3'd7};
        vecs[10] = '{1'b1, 32'd8,  1'b1, 32'd8,  1'b1, 1'b1, 3'd7};
        vecs[11] = '{1'b0, 32'd0,  1'b0, 32'd0,  1'b0, 1'b0, 3'd7};
        for (int i = 0; i < 12; i++) begin
            a_s_valid = vecs[i].sv; a_s_data = vecs[i].sd;
            a_e_valid = vecs[i].ev; a_e_data = vecs[i].ed;
            #1;
            check($sformatf("vec%0d s_ready", i), 32'(a_s_ready), 32'(vecs[i].exp_sr));
            check($sformatf("vec%0d e_ready", i), 32'(a_e_ready), 32'(vecs[i].exp_er));
            @(posedge clk);
            #1;
            check_a_flags($sformatf("vec%0d", i), vecs[i].exp_pc, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic drive_a_word(input logic [31:0] act, input logic [31:0] exp);
        a_s_valid = 1'b1; a_s_data = act;
        a_e_valid = 1'b1; a_e_data = exp;
        @(negedge clk);
    endtask

    task automatic run_mismatch_and_reset();
        apply_reset();
        drive_a_word(32'd1, 32'd1);
        drive_a_word(32'd2, 32'd2);
        drive_a_word(32'hDEAD, 32'hBEEF);
        a_s_valid = 1'b0; a_s_data = '0;
        a_e_valid = 1'b1; a_e_data = 32'h1234;
        #1;
        check_a_flags("mismatch", 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        check("mismatch s_ready after", 32'(a_s_ready), 32'd0);
        check("mismatch e_ready after", 32'(a_e_ready), 32'd0);
        // asynchronous reset away from any clock edge
        @(posedge clk);
        a_e_valid = 1'b0;
        #3;
        resetn = 1'b0;
        #1;
        check_a_flags("async reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("async reset s_ready", 32'(a_s_ready), 32'd0);
        check("async reset e_ready", 32'(a_e_ready), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        drive_a_word(32'h55, 32'h55);
        a_s_valid = 1'b0; a_e_valid = 1'b0;
        check_a_flags("after reset", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_protocol(input logic drop_valid);
        apply_reset();
        a_e_valid = 1'b0;
        a_s_valid = 1'b1; a_s_data = 32'hA5A5_0001;
        #1;
        check("protocol stalled s_ready", 32'(a_s_ready), 32'd0);
        @(negedge clk);
        if (drop_valid) a_s_valid = 1'b0;
        else a_s_data = 32'hA5A5_0002;
        @(posedge clk);
        #1;
        check_a_flags(drop_valid ? "protocol drop" : "protocol data", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        a_s_valid = 1'b0;
    endtask

    task automatic run_timeout();
        apply_reset();
        a_e_valid = 1'b1; a_e_data = 32'h77;
        a_s_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check_a_flags("timeout 14", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_a_flags("timeout 15", 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("timeout s_ready", 32'(a_s_ready), 32'd0);
        @(negedge clk);
        a_e_valid = 1'b0;
    endtask

    task automatic run_stream();
        logic [31:0] exp_q[$];
        logic [31:0] act_q[$];
        logic [31:0] w;
        logic [31:0] popped;
        logic [15:0] lfsr_m;
        logic        hold;
        logic        exp_sr;
        logic        acc;
        int          cyc;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            exp_q.push_back(w);
            act_q.push_back(w);
        end
        apply_reset();
        lfsr_m = 16'hACE1;
        hold = 1'b0;
        cyc = 0;
        while (act_q.size() > 0 && cyc < 2000) begin
            if (!hold) b_s_valid = ($urandom_range(0, 3) != 0);
            b_s_data  = b_s_valid ? act_q[0] : $urandom;
            b_e_valid = (exp_q.size() > 0);
            b_e_data  = (exp_q.size() > 0) ? exp_q[0] : 32'd0;
            #1;
            exp_sr = b_e_valid && (lfsr_m[1:0] != 2'b00);
            acc    = b_s_valid && exp_sr;
            check("stream s_ready", 32'(b_s_ready), 32'(exp_sr));
            check("stream e_ready", 32'(b_e_ready), 32'(acc));
            if (b_e_ready && exp_q.size() > 0) begin
                popped = exp_q.pop_front();
                check("stream popped word", b_s_data, popped);
            end
            @(posedge clk);
            lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
            if (acc) void'(act_q.pop_front());
            hold = b_s_valid && !acc;
            cyc++;
            @(negedge clk);
        end
        check("stream finished within budget", 32'(act_q.size()), 32'd0);
        b_s_valid = 1'b0; b_e_valid = 1'b0;
        #1;
        check("stream pass_count",   32'(b_pass),  32'd64);
        check("stream err_mismatch", 32'(b_mis),   32'd0);
        check("stream err_protocol", 32'(b_pro),   32'd0);
        check("stream err_timeout",  32'(b_tmo),   32'd0);
        check("stream state",        32'(b_state), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        apply_reset();
        #1;
        check_a_flags("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset s_ready", 32'(a_s_ready), 32'd0);
        check("reset b pass_count", 32'(b_pass), 32'd0);
        @(negedge clk);
        run_vectors();
        run_mismatch_and_reset();
        run_protocol(1'b0);
        run_protocol(1'b1);
        run_timeout();
        run_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
